// File: rtl/ofs_ready_latency_sink.sv
// Receiving end of a ready-latency link: grants credit on s_ready, absorbs the beats
// that arrive READY_LATENCY cycles later and replays them on a valid/ready master port.
module ofs_ready_latency_sink #(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned READY_LATENCY = 2,
    parameter int unsigned DEPTH         = 4
) (
    input  logic             clk,
    input  logic             rst,
    output logic             s_ready,
    input  logic             s_valid,
    input  logic [WIDTH-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             err_overflow
);
    localparam int unsigned RL    = READY_LATENCY;
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);
    localparam int unsigned SUM_W = $clog2(DEPTH + READY_LATENCY + 1);
    localparam int unsigned IGN_W = $clog2(READY_LATENCY + 1);

    logic [PTR_W-1:0] wr_q, wr_d;
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [RL-1:0]    hist_q, hist_d;
    logic             s_ready_q, s_ready_d;
    logic             m_valid_q, m_valid_d;
    logic             err_q, err_d;
    logic [IGN_W-1:0] ign_q, ign_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [WIDTH-1:0] m_data_q, m_data_d;

    logic             live_c;
    logic             full_c;
    logic             pop_c;
    logic             push_c;
    logic             overflow_c;
    logic             ungranted_c;
    logic [SUM_W-1:0] outstanding_c;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Beats landing inside the post-reset window belong to grants issued before reset.
    always_comb begin
        live_c      = s_valid && (ign_q == '0);
        full_c      = (occ_q == OCC_W'(DEPTH));
        pop_c       = m_valid_q && m_ready;
        push_c      = live_c && (!full_c || pop_c);
        overflow_c  = live_c && full_c && !pop_c;
        ungranted_c = live_c && !hist_q[RL-1];
    end

    // FIFO pointers, occupancy and storage.
    always_comb begin
        wr_d  = push_c ? ptr_inc(wr_q) : wr_q;
        rd_d  = pop_c  ? ptr_inc(rd_q) : rd_q;
        occ_d = occ_q;
        if (push_c && !pop_c) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (pop_c && !push_c) begin
            occ_d = occ_q - OCC_W'(1);
        end
        mem_d = mem_q;
        if (push_c) begin
            mem_d[wr_q] = s_data;
        end
        // Reading the post-write array covers a push into an empty (or just emptied) FIFO.
        m_data_d  = mem_d[rd_d];
        m_valid_d = (occ_d != '0);
    end

    // Credit: grants still in flight plus what will be stored must stay below DEPTH.
    always_comb begin
        outstanding_c = SUM_W'(s_ready_q);
        for (int i = 0; i < int'(RL) - 1; i++) begin
            outstanding_c = outstanding_c + SUM_W'(hist_q[i]);
        end
        hist_d    = hist_q << 1;
        hist_d[0] = s_ready_q;
        s_ready_d = (SUM_W'(occ_d) + outstanding_c) < SUM_W'(DEPTH);
        err_d     = err_q || overflow_c || ungranted_c;
        ign_d     = (ign_q != '0) ? ign_q - IGN_W'(1) : ign_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q      <= '0;
            rd_q      <= '0;
            occ_q     <= '0;
            hist_q    <= '0;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
            err_q     <= 1'b0;
            ign_q     <= IGN_W'(RL);
        end else begin
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            occ_q     <= occ_d;
            hist_q    <= hist_d;
            s_ready_q <= s_ready_d;
            m_valid_q <= m_valid_d;
            err_q     <= err_d;
            ign_q     <= ign_d;
        end
    end

    // Payload storage carries no reset; contents are qualified by occupancy.
    always_ff @(posedge clk) begin
        mem_q    <= mem_d;
        m_data_q <= m_data_d;
    end

    assign s_ready      = s_ready_q;
    assign m_valid      = m_valid_q;
    assign m_data       = m_data_q;
    assign err_overflow = err_q;

endmodule

// File: tb/tb_ofs_ready_latency_sink.sv
// Bench for ofs_ready_latency_sink: directed vector table on an RL=2/DEPTH=4 instance,
// then queue-model checked streaming and random traffic on RL=2/4 and RL=3/5 instances.
module tb_ofs_ready_latency_sink;

    typedef struct {
        logic       chk;
        logic       rst;
        logic       sv;
        logic [7:0] sd;
        logic       mr;
        logic       e_sr;
        logic       e_mv;
        logic [7:0] e_md;
        logic       c_md;
        logic       e_err;
    } vec_t;

    logic       clk = 1'b0;
    logic       a_rst, a_s_ready, a_s_valid, a_m_valid, a_m_ready, a_err;
    logic [7:0] a_s_data, a_m_data;
    logic       b_rst, b_s_ready, b_s_valid, b_m_valid, b_m_ready, b_err;
    logic [7:0] b_s_data, b_m_data;

    int checks = 0;
    int errors = 0;
    vec_t tbl[$];

    ofs_ready_latency_sink #(.WIDTH(8), .READY_LATENCY(2), .DEPTH(4)) dut_a (
        .clk(clk), .rst(a_rst), .s_ready(a_s_ready), .s_valid(a_s_valid), .s_data(a_s_data),
        .m_valid(a_m_valid), .m_ready(a_m_ready), .m_data(a_m_data), .err_overflow(a_err)
    );

    ofs_ready_latency_sink #(.WIDTH(8), .READY_LATENCY(3), .DEPTH(5)) dut_b (
        .clk(clk), .rst(b_rst), .s_ready(b_s_ready), .s_valid(b_s_valid), .s_data(b_s_data),
        .m_valid(b_m_valid), .m_ready(b_m_ready), .m_data(b_m_data), .err_overflow(b_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic chk, input logic rst, input logic sv,
                                input logic [7:0] sd, input logic mr, input logic e_sr,
                                input logic e_mv, input logic [7:0] e_md, input logic c_md,
                                input logic e_err);
        vec_t v;
        v.chk = chk; v.rst = rst; v.sv = sv; v.sd = sd; v.mr = mr;
        v.e_sr = e_sr; v.e_mv = e_mv; v.e_md = e_md; v.c_md = c_md; v.e_err = e_err;
        return v;
    endfunction

    task automatic set_in(input int sel, input logic rst, input logic sv,
                          input logic [7:0] sd, input logic mr);
        if (sel == 0) begin
            a_rst = rst; a_s_valid = sv; a_s_data = sd; a_m_ready = mr;
        end else begin
            b_rst = rst; b_s_valid = sv; b_s_data = sd; b_m_ready = mr;
        end
    endtask

    // Reference: FIFO as a queue, grants as a per-cycle array, credit from the occupancy rule.
    task automatic run_model(input int sel, input int rl, input int depth, input int nbeats,
                             input int mr_pct, input int sv_pct, input bit sr_const,
                             input int maxc, input string tag);
        logic [7:0] q[$];
        bit         g[$];
        int         sent = 0;
        int         t = 0;
        int         dut_pops = 0;
        bit         msr = 1'b0;
        bit         merr = 1'b0;
        logic       o_sr, o_mv, o_err;
        logic [7:0] o_md;
        set_in(sel, 1'b1, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        @(negedge clk);
        while ((sent < nbeats || q.size() != 0) && t < maxc) begin
            bit         sv, mr, pop, full;
            logic [7:0] d;
            int         outst;
            @(negedge clk);
            if (sel == 0) begin
                o_sr = a_s_ready; o_mv = a_m_valid; o_md = a_m_data; o_err = a_err;
            end else begin
                o_sr = b_s_ready; o_mv = b_m_valid; o_md = b_m_data; o_err = b_err;
            end
            check($sformatf("%s_c%0d_s_ready", tag, t), 32'(o_sr), 32'(msr));
            check($sformatf("%s_c%0d_m_valid", tag, t), 32'(o_mv), 32'(q.size() != 0));
            if (q.size() != 0)
                check($sformatf("%s_c%0d_m_data", tag, t), 32'(o_md), 32'(q[0]));
            check($sformatf("%s_c%0d_err", tag, t), 32'(o_err), 32'(merr));
            if (sr_const && t >= 1)
                check($sformatf("%s_c%0d_s_ready_const", tag, t), 32'(o_sr), 32'd1);
            sv = (t >= rl) && g[t - rl] && (sent < nbeats) && ($urandom_range(99) < sv_pct);
            d  = (sel == 0) ? 8'(sent + 1) : 8'($urandom);
            mr = ($urandom_range(99) < mr_pct);
            set_in(sel, 1'b0, sv, d, mr);
            if (o_mv && mr) dut_pops++;
            full = (q.size() == depth);
            pop  = (q.size() != 0) && mr;
            if (pop) void'(q.pop_front());
            if (sv) begin
                if (!full || pop) q.push_back(d);
                else merr = 1'b1;
                sent++;
            end
            g.push_back(msr);
            outst = 0;
            for (int k = t - rl + 1; k <= t; k++)
                if (k >= 0 && g[k]) outst++;
            msr = ((q.size() + outst) < depth);
            t++;
        end
        check($sformatf("%s_completed_within_budget", tag), 32'(t < maxc), 32'd1);
        @(negedge clk);
        set_in(sel, 1'b0, 1'b0, 8'h00, 1'b1);
        check($sformatf("%s_final_m_valid", tag), 32'(sel == 0 ? a_m_valid : b_m_valid), 32'd0);
        check($sformatf("%s_beats_out", tag), 32'(dut_pops), 32'(nbeats));
    endtask

    initial begin
        set_in(0, 1'b1, 1'b0, 8'h00, 1'b0);
        set_in(1, 1'b1, 1'b0, 8'h00, 1'b0);

        // chk rst sv sd mr | s_ready m_valid m_data chk_data err
        tbl.push_back(mk(0, 1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(1, 1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(1, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0));  // c0: no grant on release cycle
        tbl.push_back(mk(1, 0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0));
        tbl.push_back(mk(1, 0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0));
        tbl.push_back(mk(1, 0, 1, 8'h11, 0, 1, 0, 8'h00, 0, 0));
        tbl.push_back(mk(1, 0, 1, 8'h22, 0, 1, 1, 8'h11, 1, 0));
        tbl.push_back(mk(1, 0, 1, 8'h33, 0, 0, 1, 8'h11, 1, 0));
        tbl.push_back(mk(1, 0, 1, 8'h44, 0, 0, 1, 8'h11, 1, 0));
        tbl.push_back(mk(1, 0, 1, 8'h55, 0, 0, 1, 8'h11, 1, 0));  // c7: full, ungranted 0x55
        tbl.push_back(mk(1, 0, 0, 8'h00, 1, 0, 1, 8'h11, 1, 1));
        tbl.push_back(mk(1, 0, 0, 8'h00, 1, 1, 1, 8'h22, 1, 1));
        tbl.push_back(mk(1, 0, 0, 8'h00, 1, 1, 1, 8'h33, 1, 1));
        tbl.push_back(mk(1, 0, 0, 8'h00, 1, 1, 1, 8'h44, 1, 1));
        tbl.push_back(mk(1, 0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 1));
        tbl.push_back(mk(1, 0, 1, 8'hC1, 0, 1, 0, 8'h00, 0, 1));
        tbl.push_back(mk(1, 0, 1, 8'hC2, 0, 1, 1, 8'hC1, 1, 1));
        tbl.push_back(mk(1, 0, 1, 8'hC3, 0, 0, 1, 8'hC1, 1, 1));
        tbl.push_back(mk(1, 1, 1, 8'hC4, 0, 0, 1, 8'hC1, 1, 1));  // c16: reset with occ=3
        tbl.push_back(mk(1, 0, 1, 8'hE1, 1, 0, 0, 8'h00, 0, 0));  // late beats for old grants
        tbl.push_back(mk(1, 0, 1, 8'hE2, 1, 1, 0, 8'h00, 0, 0));
        tbl.push_back(mk(1, 0, 0, 8'h00, 1, 1, 0, 8'h00, 0, 0));
        tbl.push_back(mk(1, 0, 1, 8'hD1, 1, 1, 0, 8'h00, 0, 0));
        tbl.push_back(mk(1, 0, 1, 8'hD2, 1, 1, 1, 8'hD1, 1, 0));
        tbl.push_back(mk(1, 0, 0, 8'h00, 1, 1, 1, 8'hD2, 1, 0));
        tbl.push_back(mk(1, 0, 0, 8'h00, 1, 1, 0, 8'h00, 0, 0));

        foreach (tbl[i]) begin
            @(negedge clk);
            if (tbl[i].chk) begin
                check($sformatf("tbl%0d_s_ready", i), 32'(a_s_ready), 32'(tbl[i].e_sr));
                check($sformatf("tbl%0d_m_valid", i), 32'(a_m_valid), 32'(tbl[i].e_mv));
                if (tbl[i].c_md)
                    check($sformatf("tbl%0d_m_data", i), 32'(a_m_data), 32'(tbl[i].e_md));
                check($sformatf("tbl%0d_err", i), 32'(a_err), 32'(tbl[i].e_err));
            end
            set_in(0, tbl[i].rst, tbl[i].sv, tbl[i].sd, tbl[i].mr);
        end

        run_model(0, 2, 4, 100, 100, 100, 1'b1, 1000, "stream");
        run_model(0, 2, 4, 500, 50, 80, 1'b0, 5000, "rand_a");
        run_model(1, 3, 5, 10000, 50, 85, 1'b0, 60000, "rand_b");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
